// File: rtl/writeback_pipe_if.sv
// rtl/writeback_pipe_if.sv - MEM-to-writeback handshake and register-file/PC result bundle
interface writeback_pipe_if #(
    parameter int DWIDTH   = 32,
    parameter int AWIDTH   = 32,
    parameter int RWIDTH   = 5,
    parameter int CNTWIDTH = 64
);
    logic                valid_i;
    logic                stall_i;
    logic                flush_i;
    logic [AWIDTH-1:0]   pc_i;
    logic [DWIDTH-1:0]   alu_res_i;
    logic [DWIDTH-1:0]   memory_data_i;
    logic [DWIDTH-1:0]   imm_i;
    logic [1:0]          wbsel_i;
    logic [2:0]          funct3_i;
    logic                regwren_i;
    logic [RWIDTH-1:0]   rd_i;
    logic                pcsel_i;

    logic                wb_valid_o;
    logic                regwren_o;
    logic [RWIDTH-1:0]   rd_o;
    logic [DWIDTH-1:0]   writeback_data_o;
    logic [AWIDTH-1:0]   next_pc_o;
    logic                misalign_o;
    logic [CNTWIDTH-1:0] instret_o;

    modport master (
        output valid_i, stall_i, flush_i, pc_i, alu_res_i, memory_data_i, imm_i,
               wbsel_i, funct3_i, regwren_i, rd_i, pcsel_i,
        input  wb_valid_o, regwren_o, rd_o, writeback_data_o, next_pc_o, misalign_o, instret_o
    );

    modport slave (
        input  valid_i, stall_i, flush_i, pc_i, alu_res_i, memory_data_i, imm_i,
               wbsel_i, funct3_i, regwren_i, rd_i, pcsel_i,
        output wb_valid_o, regwren_o, rd_o, writeback_data_o, next_pc_o, misalign_o, instret_o
    );
endinterface

// File: rtl/writeback_pipe.sv
// rtl/writeback_pipe.sv - registered write-back stage with load alignment, next PC and retire counter
module writeback_pipe #(
    parameter int                DWIDTH   = 32,
    parameter int                AWIDTH   = 32,
    parameter int                RWIDTH   = 5,
    parameter int                CNTWIDTH = 64,
    parameter logic [AWIDTH-1:0] RESET_PC = AWIDTH'(32'h0100_0000)
) (
    input  logic             clk,
    input  logic             reset,
    writeback_pipe_if.slave  bus
);
    logic                r_valid;
    logic [AWIDTH-1:0]   r_pc;
    logic [DWIDTH-1:0]   r_alu;
    logic [DWIDTH-1:0]   r_mem;
    logic [DWIDTH-1:0]   r_imm;
    logic [1:0]          r_wbsel;
    logic [2:0]          r_funct3;
    logic                r_regwren;
    logic [RWIDTH-1:0]   r_rd;
    logic [AWIDTH-1:0]   r_next_pc;
    logic [CNTWIDTH-1:0] r_instret;

    logic                w_retire;
    logic [1:0]          w_off;
    logic [7:0]          w_byte;
    logic [15:0]         w_half;
    logic [DWIDTH-1:0]   w_load;
    logic [DWIDTH-1:0]   w_data;
    logic [AWIDTH-1:0]   w_pc4;
    logic                w_is_byte;
    logic                w_is_half;
    logic                w_is_word;

    // A held instruction leaves on release of stall, or when a flush pushes it out.
    assign w_retire = r_valid & (~bus.stall_i | bus.flush_i);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_valid   <= 1'b0;
            r_pc      <= '0;
            r_alu     <= '0;
            r_mem     <= '0;
            r_imm     <= '0;
            r_wbsel   <= 2'd0;
            r_funct3  <= 3'd0;
            r_regwren <= 1'b0;
            r_rd      <= '0;
            r_next_pc <= RESET_PC;
            r_instret <= '0;
        end else begin
            if (w_retire) begin
                r_instret <= r_instret + CNTWIDTH'(1);
            end
            if (bus.flush_i) begin
                r_valid <= 1'b0;
            end else if (!bus.stall_i) begin
                r_valid   <= bus.valid_i;
                r_pc      <= bus.pc_i;
                r_alu     <= bus.alu_res_i;
                r_mem     <= bus.memory_data_i;
                r_imm     <= bus.imm_i;
                r_wbsel   <= bus.wbsel_i;
                r_funct3  <= bus.funct3_i;
                r_regwren <= bus.regwren_i;
                r_rd      <= bus.rd_i;
                if (bus.valid_i) begin
                    r_next_pc <= bus.pcsel_i ? AWIDTH'(bus.alu_res_i) : bus.pc_i + AWIDTH'(4);
                end
            end
        end
    end

    assign w_off     = r_alu[1:0];
    assign w_pc4     = r_pc + AWIDTH'(4);
    assign w_is_byte = (r_funct3 == 3'b000) | (r_funct3 == 3'b100);
    assign w_is_half = (r_funct3 == 3'b001) | (r_funct3 == 3'b101);
    assign w_is_word = ~w_is_byte & ~w_is_half;

    always_comb begin
        w_byte = r_mem[7:0];
        case (w_off)
            2'd0: w_byte = r_mem[7:0];
            2'd1: w_byte = r_mem[15:8];
            2'd2: w_byte = r_mem[23:16];
            2'd3: w_byte = r_mem[31:24];
            default: w_byte = r_mem[7:0];
        endcase
        w_half = w_off[1] ? r_mem[31:16] : r_mem[15:0];
        case (r_funct3)
            3'b000:  w_load = {{(DWIDTH-8){w_byte[7]}}, w_byte};
            3'b100:  w_load = {{(DWIDTH-8){1'b0}}, w_byte};
            3'b001:  w_load = {{(DWIDTH-16){w_half[15]}}, w_half};
            3'b101:  w_load = {{(DWIDTH-16){1'b0}}, w_half};
            default: w_load = r_mem;
        endcase
    end

    always_comb begin
        w_data = r_alu;
        case (r_wbsel)
            2'd0:    w_data = r_alu;
            2'd1:    w_data = w_load;
            2'd2:    w_data = DWIDTH'(w_pc4);
            2'd3:    w_data = r_imm;
            default: w_data = r_alu;
        endcase
    end

    assign bus.wb_valid_o       = r_valid;
    assign bus.regwren_o        = r_valid & r_regwren & (r_rd != '0);
    assign bus.rd_o             = r_rd;
    assign bus.writeback_data_o = w_data;
    assign bus.next_pc_o        = r_next_pc;
    assign bus.misalign_o       = r_valid & (r_wbsel == 2'd1) &
                                  ((w_is_half & w_off[0]) | (w_is_word & (w_off != 2'd0)));
    assign bus.instret_o        = r_instret;
endmodule

// File: tb/tb_writeback_pipe.sv
// tb/tb_writeback_pipe.sv - randomized and directed self-checking bench for writeback_pipe
module tb_writeback_pipe;
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    writeback_pipe_if bus ();
    writeback_pipe_if #(.CNTWIDTH(4)) bus2 ();

    writeback_pipe dut (.clk(clk), .reset(reset), .bus(bus));
    writeback_pipe #(.CNTWIDTH(4)) dut2 (.clk(clk), .reset(reset), .bus(bus2));

    assign bus2.valid_i       = bus.valid_i;
    assign bus2.stall_i       = bus.stall_i;
    assign bus2.flush_i       = bus.flush_i;
    assign bus2.pc_i          = bus.pc_i;
    assign bus2.alu_res_i     = bus.alu_res_i;
    assign bus2.memory_data_i = bus.memory_data_i;
    assign bus2.imm_i         = bus.imm_i;
    assign bus2.wbsel_i       = bus.wbsel_i;
    assign bus2.funct3_i      = bus.funct3_i;
    assign bus2.regwren_i     = bus.regwren_i;
    assign bus2.rd_i          = bus.rd_i;
    assign bus2.pcsel_i       = bus.pcsel_i;

    int n_cmp = 0;
    int n_err = 0;

    // Reference: the instruction currently in the stage, plus next PC and retire counts.
    logic        m_valid = 1'b0;
    logic [31:0] m_pc = 0, m_alu = 0, m_mem = 0, m_imm = 0;
    logic [1:0]  m_wbsel = 0;
    logic [2:0]  m_f3 = 0;
    logic        m_regwren = 1'b0;
    logic [4:0]  m_rd = 0;
    logic [31:0] m_next_pc = 32'h0100_0000;
    longint unsigned m_instret = 0;
    int unsigned m_instret4 = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] ref_load(input logic [31:0] mem, input logic [31:0] addr,
                                              input logic [2:0] f3);
        int unsigned off;
        logic [31:0] b, h;
        off = addr % 4;
        b = (mem >> (8 * off)) & 32'hFF;
        h = (off >= 2) ? (mem >> 16) : (mem & 32'hFFFF);
        case (f3)
            3'b000:  return (b >= 128) ? b + 32'hFFFF_FF00 : b;
            3'b100:  return b;
            3'b001:  return (h >= 32768) ? h + 32'hFFFF_0000 : h;
            3'b101:  return h;
            default: return mem;
        endcase
    endfunction

    function automatic logic [31:0] ref_data();
        case (m_wbsel)
            2'd0:    return m_alu;
            2'd1:    return ref_load(m_mem, m_alu, m_f3);
            2'd2:    return m_pc + 32'd4;
            default: return m_imm;
        endcase
    endfunction

    function automatic logic ref_misalign();
        int unsigned off;
        logic half, word;
        off  = m_alu % 4;
        half = (m_f3 == 3'b001) || (m_f3 == 3'b101);
        word = !half && (m_f3 != 3'b000) && (m_f3 != 3'b100);
        return m_valid && (m_wbsel == 2'd1) && ((half && (off % 2 == 1)) || (word && off != 0));
    endfunction

    initial begin
        forever begin
            @(posedge clk);
            if (reset) begin
                m_valid = 0; m_pc = 0; m_alu = 0; m_mem = 0; m_imm = 0; m_wbsel = 0;
                m_f3 = 0; m_regwren = 0; m_rd = 0; m_next_pc = 32'h0100_0000;
                m_instret = 0; m_instret4 = 0;
            end else begin
                if (m_valid && (!bus.stall_i || bus.flush_i)) begin
                    m_instret++;
                    m_instret4 = (m_instret4 + 1) % 16;
                end
                if (bus.flush_i) begin
                    m_valid = 0;
                end else if (!bus.stall_i) begin
                    m_valid = bus.valid_i; m_pc = bus.pc_i; m_alu = bus.alu_res_i;
                    m_mem = bus.memory_data_i; m_imm = bus.imm_i; m_wbsel = bus.wbsel_i;
                    m_f3 = bus.funct3_i; m_regwren = bus.regwren_i; m_rd = bus.rd_i;
                    if (bus.valid_i)
                        m_next_pc = bus.pcsel_i ? bus.alu_res_i : bus.pc_i + 32'd4;
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            chk("wb_valid", 64'(bus.wb_valid_o), 64'(m_valid));
            chk("regwren", 64'(bus.regwren_o), 64'(m_valid && m_regwren && m_rd != 0));
            chk("next_pc", 64'(bus.next_pc_o), 64'(m_next_pc));
            chk("instret", bus.instret_o, m_instret);
            chk("instret4", 64'(bus2.instret_o), 64'(m_instret4));
            chk("misalign", 64'(bus.misalign_o), 64'(ref_misalign()));
            if (m_valid) begin
                chk("rd", 64'(bus.rd_o), 64'(m_rd));
                chk("wb_data", 64'(bus.writeback_data_o), 64'(ref_data()));
            end
        end
    end

    task automatic drv(input logic v, input logic [31:0] pc, input logic [31:0] alu,
                       input logic [31:0] mem, input logic [31:0] imm, input logic [1:0] ws,
                       input logic [2:0] f3, input logic rw, input logic [4:0] rd,
                       input logic ps, input logic st, input logic fl);
        bus.valid_i = v; bus.pc_i = pc; bus.alu_res_i = alu; bus.memory_data_i = mem;
        bus.imm_i = imm; bus.wbsel_i = ws; bus.funct3_i = f3; bus.regwren_i = rw;
        bus.rd_i = rd; bus.pcsel_i = ps; bus.stall_i = st; bus.flush_i = fl;
    endtask

    task automatic idle();
        drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        idle();
        repeat (2) @(negedge clk);
        reset = 0;
        repeat (3) @(negedge clk);
        chk("rst_wb_valid", 64'(bus.wb_valid_o), 64'd0);
        chk("rst_regwren", 64'(bus.regwren_o), 64'd0);
        chk("rst_next_pc", 64'(bus.next_pc_o), 64'h0100_0000);
        chk("rst_instret", bus.instret_o, 64'd0);
        chk("rst_rd", 64'(bus.rd_o), 64'd0);
        chk("rst_data", 64'(bus.writeback_data_o), 64'd0);

        drv(1, 32'h100, 32'h1234, 0, 0, 2'd0, 3'b010, 1, 5'd5, 0, 0, 0);
        @(negedge clk);
        chk("alu_regwren", 64'(bus.regwren_o), 64'd1);
        chk("alu_rd", 64'(bus.rd_o), 64'd5);
        chk("alu_data", 64'(bus.writeback_data_o), 64'h1234);
        chk("alu_next_pc", 64'(bus.next_pc_o), 64'h104);
        chk("alu_instret0", bus.instret_o, 64'd0);
        idle();
        @(negedge clk);
        chk("alu_instret1", bus.instret_o, 64'd1);

        drv(1, 32'h110, 32'h2, 32'h80FF_7F01, 0, 2'd1, 3'b000, 1, 5'd6, 0, 0, 0);
        @(negedge clk);
        chk("lb_off2", 64'(bus.writeback_data_o), 64'hFFFF_FFFF);
        drv(1, 32'h114, 32'h3, 32'h80FF_7F01, 0, 2'd1, 3'b100, 1, 5'd6, 0, 0, 0);
        @(negedge clk);
        chk("lbu_off3", 64'(bus.writeback_data_o), 64'h80);
        drv(1, 32'h118, 32'h2, 32'h80FF_7F01, 0, 2'd1, 3'b001, 1, 5'd6, 0, 0, 0);
        @(negedge clk);
        chk("lh_off2", 64'(bus.writeback_data_o), 64'hFFFF_80FF);
        chk("lh_off2_mis", 64'(bus.misalign_o), 64'd0);
        drv(1, 32'h11C, 32'h1, 32'h80FF_7F01, 0, 2'd1, 3'b001, 1, 5'd6, 0, 0, 0);
        @(negedge clk);
        chk("lh_off1_mis", 64'(bus.misalign_o), 64'd1);
        chk("lh_off1", 64'(bus.writeback_data_o), 64'h0000_7F01);

        drv(1, 32'h200, 32'h400, 0, 0, 2'd2, 3'b000, 1, 5'd1, 1, 0, 0);
        @(negedge clk);
        chk("jal_data", 64'(bus.writeback_data_o), 64'h204);
        chk("jal_next_pc", 64'(bus.next_pc_o), 64'h400);
        chk("jal_regwren", 64'(bus.regwren_o), 64'd1);
        drv(1, 32'h200, 32'h400, 0, 0, 2'd2, 3'b000, 1, 5'd0, 1, 0, 0);
        @(negedge clk);
        chk("jal_x0_regwren", 64'(bus.regwren_o), 64'd0);
        idle();
        @(negedge clk);
        chk("count7", bus.instret_o, 64'd7);
        chk("count7_4b", 64'(bus2.instret_o), 64'd7);

        drv(1, 32'h300, 32'hAAAA, 0, 0, 2'd0, 3'b000, 1, 5'd7, 0, 0, 0);
        @(negedge clk);
        drv(1, 32'hDEAD_0000, 32'h5555, 0, 0, 2'd3, 3'b000, 1, 5'd9, 1, 1, 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("stall_data", 64'(bus.writeback_data_o), 64'hAAAA);
            chk("stall_rd", 64'(bus.rd_o), 64'd7);
            chk("stall_instret", bus.instret_o, 64'd7);
            chk("stall_next_pc", 64'(bus.next_pc_o), 64'h304);
        end
        idle();
        @(negedge clk);
        chk("release_instret", bus.instret_o, 64'd8);
        chk("release_valid", 64'(bus.wb_valid_o), 64'd0);

        drv(1, 32'h500, 32'h55, 0, 0, 2'd0, 3'b000, 1, 5'd8, 0, 0, 0);
        @(negedge clk);
        drv(1, 32'h900, 32'h990, 0, 0, 2'd0, 3'b000, 1, 5'd8, 1, 1, 1);
        @(negedge clk);
        chk("flush_valid", 64'(bus.wb_valid_o), 64'd0);
        chk("flush_instret", bus.instret_o, 64'd9);
        chk("flush_next_pc", 64'(bus.next_pc_o), 64'h504);

        for (int i = 0; i < 7; i++) begin
            drv(1, 32'h700 + 32'(4 * i), 32'(i), 0, 0, 2'd0, 3'b000, 1, 5'(i + 1), 0, 0, 0);
            @(negedge clk);
        end
        idle();
        @(negedge clk);
        chk("wrap_4b", 64'(bus2.instret_o), 64'd0);
        chk("wrap_64b", bus.instret_o, 64'd16);

        drv(1, 32'h600, 32'h77, 0, 0, 2'd0, 3'b000, 1, 5'd9, 0, 0, 0);
        @(negedge clk);
        bus.stall_i = 1;
        @(negedge clk);
        reset = 1;
        @(negedge clk);
        chk("rmid_valid", 64'(bus.wb_valid_o), 64'd0);
        chk("rmid_regwren", 64'(bus.regwren_o), 64'd0);
        chk("rmid_rd", 64'(bus.rd_o), 64'd0);
        chk("rmid_data", 64'(bus.writeback_data_o), 64'd0);
        chk("rmid_next_pc", 64'(bus.next_pc_o), 64'h0100_0000);
        chk("rmid_instret", bus.instret_o, 64'd0);
        reset = 0;
        idle();

        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            drv($urandom_range(0, 3) != 0, $urandom, $urandom, $urandom, $urandom,
                2'($urandom), 3'($urandom), 1'($urandom),
                ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom), 1'($urandom),
                $urandom_range(0, 3) == 0, $urandom_range(0, 9) == 0);
            reset = ($urandom_range(0, 99) == 0);
        end
        reset = 0;
        idle();
        repeat (3) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
